// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line, write-back / write-allocate data cache
// controller sitting between a CPU request port and a memory port.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   cpu_req/cpu_ready   CPU request valid (held until ready) / one-cycle completion pulse
//   cpu_addr, cpu_rw    word-aligned byte address; 1 = write, 0 = read
//   cpu_wdata/byte_en   write data and per-byte write enables
//   cpu_rdata           line word returned with cpu_ready (merged word on writes)
//   mem_req/mem_ready   memory phase valid / memory completion
//   mem_rw              1 = write-back of victim, 0 = line fill
//   mem_addr/mem_wdata  word-aligned memory address / victim word
//   mem_rdata           fill data
//
// All outputs are registered, so the comb block computes the values they must
// hold in the *next* state. Hit detection for a new request is therefore done
// against the live CPU inputs in IDLE, so cpu_ready appears in the COMPARE
// cycle. The line write of a hit (or fill) lands on the same edge.
module dcache_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic                  cpu_rw,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_byte_en,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_req,
  output logic                  mem_rw,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic [IDX_W-1:0]  req_idx_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              req_latch;

  // Line storage: valid/dirty are reset, tag/data are not
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Registered outputs and their next values
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Line write port
  logic              line_we;
  logic [IDX_W-1:0]  line_idx;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              line_dirty;
  logic              dirty_clr;

  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic              cpu_hit;
  logic [DATA_W-1:0] hit_word;
  logic [DATA_W-1:0] fill_word;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_addr;
  logic [ADDR_W-1:0] fill_addr;
  logic [1:0]        unused_offset;

  // Byte-wise merge of new data over an old word
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  assign cpu_idx       = cpu_addr[IDX_W+1:2];
  assign cpu_tag       = cpu_addr[ADDR_W-1:IDX_W+2];
  assign unused_offset = cpu_addr[1:0];

  assign cpu_hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign hit_word     = cpu_rw ? merge_bytes(data_q[cpu_idx], cpu_wdata, cpu_byte_en)
                               : data_q[cpu_idx];
  // A write that misses is merged straight into the fill word
  assign fill_word    = rw_q ? merge_bytes(mem_rdata, wdata_q, be_q) : mem_rdata;
  assign victim_dirty = valid_q[req_idx_q] && dirty_q[req_idx_q];
  assign victim_addr  = {tag_q[req_idx_q], req_idx_q, 2'b00};
  assign fill_addr    = {req_tag_q, req_idx_q, 2'b00};

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    req_latch   = 1'b0;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = '0;
    mem_req_d   = 1'b0;
    mem_rw_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    line_we     = 1'b0;
    line_idx    = req_idx_q;
    line_tag    = req_tag_q;
    line_data   = '0;
    line_dirty  = 1'b0;
    dirty_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          req_latch = 1'b1;
          state_d   = ST_COMPARE;
          if (cpu_hit) begin
            cpu_ready_d = 1'b1;
            cpu_rdata_d = hit_word;
            if (cpu_rw) begin
              line_we    = 1'b1;
              line_idx   = cpu_idx;
              line_tag   = cpu_tag;
              line_data  = hit_word;
              line_dirty = 1'b1;
            end
          end
        end
      end

      // cpu_ready_q set here means the access already hit (or was just filled)
      ST_COMPARE: begin
        if (cpu_ready_q) begin
          state_d = ST_IDLE;
        end else if (victim_dirty) begin
          state_d     = ST_WRITEBACK;
          mem_req_d   = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = victim_addr;
          mem_wdata_d = data_q[req_idx_q];
        end else begin
          state_d    = ST_ALLOCATE;
          mem_req_d  = 1'b1;
          mem_addr_d = fill_addr;
        end
      end

      ST_WRITEBACK: begin
        if (mem_ready) begin
          dirty_clr = 1'b1;
          state_d   = ST_ALLOCATE;
        end else begin
          mem_req_d   = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end

      // First ALLOCATE cycle after a write-back is the mandatory mem_req gap
      ST_ALLOCATE: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fill_addr;
        end else if (mem_ready) begin
          line_we     = 1'b1;
          line_data   = fill_word;
          line_dirty  = rw_q;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = fill_word;
          state_d     = ST_COMPARE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch, valid/dirty and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_idx_q   <= '0;
      req_tag_q   <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (req_latch) begin
        req_idx_q <= cpu_idx;
        req_tag_q <= cpu_tag;
        rw_q      <= cpu_rw;
        wdata_q   <= cpu_wdata;
        be_q      <= cpu_byte_en;
      end
      if (line_we) begin
        valid_q[line_idx] <= 1'b1;
        dirty_q[line_idx] <= line_dirty;
      end else if (dirty_clr) begin
        dirty_q[req_idx_q] <= 1'b0;
      end
    end
  end

  // Tag/data arrays
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
